byte_serial_adder_32: RTL
=========================

Name: byte_serial_adder_32

Overview:
- Multi-cycle 32-bit add/subtract unit built around a single cla_8_bit instance.
- Processes one byte per clock, least-significant byte first, and registers the inter-byte carry between cycles.
- Sits directly upstream of the 8-bit CLA: it sequences operand bytes and the carry into it, then collects sum bytes and Cout.
- Serves as the area-reduced ALU adder path for the multi-cycle execute stage.

Parameters:
- NBYTES, 4, number of byte slices processed; data width is 8*NBYTES. The design is verified only at 4.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- data_operandA  input  32  operand A, sampled only when start is accepted.
- data_operandB  input  32  operand B, sampled only when start is accepted.
- ctrl_sub  input  1  1 = A minus B, 0 = A plus B; sampled with the operands.
- start  input  1  request a new operation.
- busy  output  1  high while byte slices are being processed.
- data_result  output  32  registered result; holds its value until the next completion.
- carry_out  output  1  carry out of bit 31. For subtract, 1 means no borrow.
- overflow  output  1  signed two's-complement overflow.
- data_resultRDY  output  1  one-cycle pulse marking valid data_result, carry_out and overflow.

Behaviour:
- Reset (reset_n low at a rising edge):
  - state goes to IDLE; byte index to 0; carry register to 0.
  - busy, data_resultRDY, data_result, carry_out and overflow all go to 0.
  - Any operation in flight is abandoned and produces no RDY pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch opA = data_operandA, opB = (ctrl_sub ? ~data_operandB : data_operandB), carry = ctrl_sub, and index = 0.
  - Move to RUN; busy goes high from the next cycle.
- RUN:
  - CLA inputs are A = opA byte[index], B = opB byte[index], Cin = carry.
  - Each edge: write S into accumulator byte[index], carry <= Cout, index <= index + 1.
  - After the edge that processes index 3, latch into the outputs:
    - data_result = full accumulator including the new byte 3;
    - carry_out = Cout of byte 3;
    - overflow = (opA[31] == opB[31]) && (S[7] of byte 3 != opA[31]).
  - Then move to DONE.
- DONE:
  - data_resultRDY = 1 for exactly this cycle; busy = 0.
  - Next state is IDLE. If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back), and the next state is RUN.
- Latency: start accepted at edge T0. Bytes 0..3 are processed at edges T1..T4. data_resultRDY is high in the cycle following T4. Issue interval is 5 cycles.
- start while in RUN is ignored. The operands are not re-sampled and there is no queuing.
- Operands and ctrl_sub may change freely after acceptance; the internal copies are used.
- The output registers change only at completion or reset. Partial sums are never visible on data_result.
- busy is 1 exactly in RUN. busy and data_resultRDY are never high together.
- The index wraps 3 -> 0 only through the RUN -> DONE -> IDLE/RUN path.
- Overflow and carry are computed on the possibly inverted opB, so subtract semantics follow two's complement.

Test Plan:
- Add 0x000000FF + 0x00000001 -> data_result 0x00000100, carry_out 0, overflow 0; RDY high exactly in the 5th cycle after the start edge; busy high 4 cycles. This exercises the carry crossing bytes 0 to 1.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow 1, carry_out 0. Add 0xFFFFFFFF + 0x00000001 -> 0x00000000, carry_out 1, overflow 0 (carry ripples through all four bytes).
- Subtract 5 - 7 -> 0xFFFFFFFE, carry_out 0, overflow 0. Subtract 0x80000000 - 0x00000001 -> 0x7FFFFFFF, carry_out 1, overflow 1.
- Pulse start again during RUN with different operands -> ignored; result matches the first operands and only one RDY pulse occurs. Then hold start=1 in the DONE cycle with 0x12345678 + 0x11111111 -> accepted, and RDY follows 5 cycles later with 0x23456789.
- Assert reset_n=0 for one cycle while index=2 -> busy, RDY, data_result, carry_out and overflow all 0 on the next cycle with no RDY pulse. A following 1 + 1 completes with 0x00000002.
- Randomised check: 1000 random operand/ctrl_sub pairs compared against a 33-bit behavioural add/sub model for data_result, carry_out and overflow.

Source files
------------

// File: rtl/byte_serial_adder_32.sv
// Byte-serial 32-bit add/subtract unit: one 8-bit CLA slice per clock, LSB first,
// with the inter-byte carry held in a register between cycles.

module cla_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       gacc;
  logic       pacc;

  // Each carry is the flattened lookahead sum of generate terms gated by
  // the propagate run above them, rather than a rippled chain.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      gacc = g[i];
      pacc = p[i];
      for (int unsigned j = 0; j < i; j++) begin
        gacc = gacc | (pacc & g[i-1-j]);
        pacc = pacc & p[i-1-j];
      end
      c[i+1] = gacc | (pacc & cin);
    end
    s    = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module byte_serial_adder_32 #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [8*NBYTES-1:0]   data_operandA,
  input  logic [8*NBYTES-1:0]   data_operandB,
  input  logic                  ctrl_sub,
  input  logic                  start,
  output logic                  busy,
  output logic [8*NBYTES-1:0]   data_result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  data_resultRDY
);
  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [7:0]    sum_byte;
  logic          sum_cout;
  logic          last;

  cla_8_bit u_cla (
    .a    (opa[{idx, 3'b000} +: 8]),
    .b    (opb[{idx, 3'b000} +: 8]),
    .cin  (carry),
    .s    (sum_byte),
    .cout (sum_cout)
  );

  // acc_next includes the byte being produced this cycle so the final
  // result can be latched on the same edge that computes the top byte.
  always_comb begin
    acc_next                     = acc;
    acc_next[{idx, 3'b000} +: 8] = sum_byte;
    last                         = (idx == IW'(NBYTES - 1));
    busy                         = (state == S_RUN);
    data_resultRDY               = (state == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      data_result <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            opa   <= data_operandA;
            opb   <= ctrl_sub ? ~data_operandB : data_operandB;
            carry <= ctrl_sub;
            idx   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= sum_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            data_result <= acc_next;
            carry_out   <= sum_cout;
            overflow    <= (opa[W-1] == opb[W-1]) && (sum_byte[7] != opa[W-1]);
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
